uart_tx_arb: RTL and testbench

- Shares the single UART transmitter (uart_ctl din/tx_en) between N_REQ byte producers using round-robin arbitration.
- Paces issue so a new byte is never presented while the previous frame is still shifting out.
- Pacing counts rising edges of the baud_gen bclk output.
- Sits between client logic and uart_ctl; uart_ctl has no busy flag, so this block owns frame timing.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/uart_tx_arb.sv | 120 ++++++++++++
 tb/tb_uart_tx_arb.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the default byte width and frame length used by the UART blocks, and
// the state encoding of the transmit arbiter.
package uart_pkg;

  localparam int UART_DW         = 8;
  localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop

  typedef enum logic {
    ST_IDLE = 1'b0,  // free to accept a byte
    ST_WAIT = 1'b1   // frame (plus gap) still shifting out
  } uart_tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request searching i_ptr+1, i_ptr+2, ... modulo
// N_REQ, so the requester at i_ptr has the lowest priority.
// Ports:
//   i_req   [N_REQ-1:0]  request vector
//   i_ptr   [IW-1:0]     index of the most recently served requester
//   o_grant [N_REQ-1:0]  one-hot grant (all zero when no request)
//   o_idx   [IW-1:0]     index of the granted requester (0 when none)
//   o_any                at least one request is asserted
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    // NOTE: every output gets a default before the search loop; a path that
    // leaves one unassigned would infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % N_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin front end for the shared UART transmitter.
// Accepts one byte at a time from N_REQ producers, strobes it into uart_ctl
// and then holds off further issue for FRAME_BITS+GAP_BITS baud ticks, since
// uart_ctl itself gives no busy indication.
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   bclk                  baud clock (synchronous to clk); rising edges pace
//   req_valid [N_REQ]     requester i has a byte pending
//   req_data  [N_REQ*DW]  byte of requester i at [i*DW +: DW]
//   req_ready [N_REQ]     one-hot accept, combinational, only in IDLE
//   din       [DW]        byte to uart_ctl, held until the next accept
//   tx_en                 one-cycle transmit strobe to uart_ctl
//   busy                  frame plus gap in flight
//   grant_id  [IW]        index of the last accepted requester
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter  int N_REQ      = 2,
  parameter  int DW         = UART_DW,
  parameter  int FRAME_BITS = UART_FRAME_BITS,
  parameter  int GAP_BITS   = 0,
  localparam int IW         = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bclk,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       din,
  output logic                tx_en,
  output logic                busy,
  output logic [IW-1:0]       grant_id
);

  localparam int TOTAL = FRAME_BITS + GAP_BITS;
  localparam int CW    = $clog2(TOTAL + 1);

  uart_tx_state_e r_state;
  uart_tx_state_e w_state_nxt;
  logic           r_bclk_q;
  logic [CW-1:0]  r_count;
  logic [IW-1:0]  r_rr;

  logic             w_tick;
  logic             w_count_tick;
  logic             w_last;
  logic             w_accept;
  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_gidx;
  logic             w_any;

  assign w_tick       = bclk & ~r_bclk_q;
  // A tick landing in the strobe cycle belongs to the previous frame's tail
  // as far as uart_ctl is concerned, so it does not advance the pacing.
  assign w_count_tick = w_tick & ~tx_en;
  assign w_last       = (r_count == CW'(TOTAL - 1));

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          req_ready   = w_grant;
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_count_tick && w_last) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values regardless of process order.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bclk_q <= 1'b0;
      r_count  <= '0;
      r_rr     <= IW'(N_REQ - 1);  // requester 0 wins first after reset
      din      <= '0;
      tx_en    <= 1'b0;
      busy     <= 1'b0;
      grant_id <= '0;
    end else begin
      r_bclk_q <= bclk;
      tx_en    <= 1'b0;
      if (w_accept) begin
        din      <= req_data[w_gidx*DW +: DW];
        tx_en    <= 1'b1;
        grant_id <= w_gidx;
        r_rr     <= w_gidx;
        busy     <= 1'b1;
        r_count  <= '0;
      end else if (r_state == ST_WAIT && w_count_tick) begin
        r_count <= r_count + 1'b1;
        if (w_last) busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb.
// A transaction-level model (bytes in flight, ticks left before the line is
// free) is compared against the DUT every cycle; directed sequences add
// literal expectations on bytes, grant order and tick spacing between strobes.
module tb_uart_tx_arb;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int FB = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bclk = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [7:0]  din;
  logic        tx_en;
  logic        busy;
  logic        grant_id;

  logic [1:0]  g_valid = '0;
  logic [15:0] g_data = '0;
  logic [1:0]  g_ready;
  logic [7:0]  g_dout;
  logic        g_tx;
  logic        g_busy;
  logic        g_gid;

  uart_tx_arb dut (
    .clk       (clk),
    .rst       (rst),
    .bclk      (bclk),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .din       (din),
    .tx_en     (tx_en),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  uart_tx_arb #(.GAP_BITS(2)) dut_gap (
    .clk       (clk),
    .rst       (rst),
    .bclk      (bclk),
    .req_valid (g_valid),
    .req_data  (g_data),
    .req_ready (g_ready),
    .din       (g_dout),
    .tx_en     (g_tx),
    .busy      (g_busy),
    .grant_id  (g_gid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         m_left;   // baud ticks still owed by the frame in flight
  int         m_rr;
  logic [7:0] m_din;
  logic       m_tx;
  int         m_gid;
  logic       m_bprev;
  int         m_pick;
  logic       m_tick;

  function automatic int model_pick(input logic [1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always_comb begin
    m_pick = model_pick(req_valid, m_rr);
    m_tick = bclk & ~m_bprev;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left  <= 0;
      m_rr    <= N - 1;
      m_din   <= '0;
      m_tx    <= 1'b0;
      m_gid   <= 0;
      m_bprev <= 1'b0;
    end else begin
      m_bprev <= bclk;
      m_tx    <= 1'b0;
      if (m_left == 0) begin
        if (m_pick >= 0) begin
          m_din  <= req_data[m_pick*DW +: DW];
          m_tx   <= 1'b1;
          m_gid  <= m_pick;
          m_rr   <= m_pick;
          m_left <= FB;
        end
      end else if (m_tick && !m_tx) begin
        m_left <= m_left - 1;
      end
    end
  end

  // ---------------- checking and monitors ----------------
  int n_chk = 0;
  int n_err = 0;
  int ph = 0;
  int rcnt = 0;
  int g_rcnt = 0;
  logic mon_prev = 1'b0;

  logic [1:0] last_ready;
  logic       last_tx;
  logic       last_busy;
  logic       last_gid;
  logic [7:0] last_din;

  logic [7:0] q_din[$];
  int         q_gid[$];
  int         q_gap[$];
  logic [7:0] gq_din[$];
  int         gq_gap[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs at the negedge: compare against the model, capture, log strobes.
  task automatic sample();
    logic       rise;
    logic [1:0] exp_ready;
    exp_ready = (m_left == 0 && m_pick >= 0) ? 2'(1 << m_pick) : 2'b00;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("tx_en", 32'(tx_en), 32'(m_tx));
    check("busy", 32'(busy), 32'(m_left != 0));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("din", 32'(din), 32'(m_din));
    last_ready = req_ready;
    last_tx    = tx_en;
    last_busy  = busy;
    last_gid   = grant_id;
    last_din   = din;
    rise     = bclk & ~mon_prev;
    mon_prev = bclk;
    if (tx_en) begin
      q_din.push_back(din);
      q_gid.push_back(int'(grant_id));
      q_gap.push_back(rcnt);
      rcnt = 0;
    end else if (rise) begin
      rcnt++;
    end
    if (g_tx) begin
      gq_din.push_back(g_dout);
      gq_gap.push_back(g_rcnt);
      g_rcnt = 0;
    end else if (rise) begin
      g_rcnt++;
    end
  endtask

  // One clock slot: bclk set at posedge+2, sampled at the negedge.
  task automatic cyc(input logic b);
    bclk = b;
    @(negedge clk);
    sample();
    @(posedge clk);
    #2;
  endtask

  // Free-running baud pattern: one high cycle in four.
  task automatic pat_cyc();
    cyc(ph == 0);
    ph = (ph + 1) % 4;
  endtask

  task automatic finish_reset();
    req_valid = '0;
    g_valid   = '0;
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b0;
    q_din.delete();
    q_gid.delete();
    q_gap.delete();
    gq_din.delete();
    gq_gap.delete();
    rcnt   = 0;
    g_rcnt = 0;
    ph     = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    finish_reset();
  endtask

  task automatic wait_main(input int n, input int budget);
    for (int i = 0; i < budget && q_din.size() < n; i++) pat_cyc();
    check("main_strobe_count", 32'(q_din.size()), 32'(n));
  endtask

  task automatic wait_gap(input int n, input int budget);
    for (int i = 0; i < budget && gq_din.size() < n; i++) begin
      pat_cyc();
      if (gq_din.size() >= 1) g_data[7:0] = 8'h0D;
    end
    check("gap_strobe_count", 32'(gq_din.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && last_busy; i++) pat_cyc();
    check("return_to_idle", 32'(last_busy), 32'(0));
  endtask

  initial begin
    #2;
    // Reset state.
    do_reset();
    check("rst_tx_en", 32'(last_tx), 32'(0));
    check("rst_busy", 32'(last_busy), 32'(0));
    check("rst_grant_id", 32'(last_gid), 32'(0));
    check("rst_din", 32'(last_din), 32'(0));

    // Single requester: same-cycle ready, strobe one cycle later, 10-tick pacing.
    req_data[7:0] = 8'h75;
    req_valid     = 2'b01;
    cyc(1'b0);
    check("t1_ready", 32'(last_ready), 32'(2'b01));
    cyc(1'b0);
    check("t1_tx_en", 32'(last_tx), 32'(1));
    check("t1_din", 32'(last_din), 32'(8'h75));
    check("t1_busy", 32'(last_busy), 32'(1));
    wait_main(2, 200);
    check("t1_din2", 32'(q_din[1]), 32'(8'h75));
    check("t1_spacing", 32'(q_gap[1]), 32'(10));
    req_valid = '0;
    wait_idle(200);

    // Two requesters held: strict alternation starting with requester 0.
    do_reset();
    req_data  = {8'h0B, 8'h0A};
    req_valid = 2'b11;
    wait_main(4, 400);
    check("alt_din0", 32'(q_din[0]), 32'(8'h0A));
    check("alt_din1", 32'(q_din[1]), 32'(8'h0B));
    check("alt_din2", 32'(q_din[2]), 32'(8'h0A));
    check("alt_din3", 32'(q_din[3]), 32'(8'h0B));
    check("alt_gid0", 32'(q_gid[0]), 32'(0));
    check("alt_gid1", 32'(q_gid[1]), 32'(1));
    check("alt_gid2", 32'(q_gid[2]), 32'(0));
    check("alt_gid3", 32'(q_gid[3]), 32'(1));
    for (int i = 1; i < 4; i++) check("alt_spacing", 32'(q_gap[i]), 32'(10));
    req_valid = '0;
    wait_idle(200);

    // GAP_BITS=2 instance streaming two bytes.
    do_reset();
    g_data[7:0] = 8'h0C;
    g_valid     = 2'b01;
    wait_gap(2, 300);
    check("gap_din0", 32'(gq_din[0]), 32'(8'h0C));
    check("gap_din1", 32'(gq_din[1]), 32'(8'h0D));
    check("gap_spacing", 32'(gq_gap[1]), 32'(12));
    g_valid = '0;
    for (int i = 0; i < 60; i++) pat_cyc();

    // bclk rise in the strobe cycle is not counted.
    do_reset();
    cyc(1'b0);
    req_data[7:0] = 8'h3C;
    req_valid     = 2'b01;
    cyc(1'b0);
    check("coin_ready", 32'(last_ready), 32'(2'b01));
    req_valid = '0;
    cyc(1'b1);
    check("coin_tx_en", 32'(last_tx), 32'(1));
    ph = 1;
    wait_idle(200);
    check("coin_ticks", 32'(rcnt), 32'(10));

    // Asynchronous reset mid-frame at count 5.
    do_reset();
    req_data  = {8'h9E, 8'h55};
    req_valid = 2'b01;
    cyc(1'b0);
    req_valid = '0;
    for (int i = 0; i < 100 && !(q_din.size() >= 1 && rcnt == 5); i++) pat_cyc();
    check("mid_rst_count", 32'(rcnt), 32'(5));
    check("mid_rst_busy_before", 32'(last_busy), 32'(1));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_tx_en", 32'(tx_en), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    finish_reset();
    req_valid = 2'b10;
    cyc(1'b0);
    check("post_rst_ready", 32'(last_ready), 32'(2'b10));
    cyc(1'b0);
    check("post_rst_tx_en", 32'(last_tx), 32'(1));
    check("post_rst_din", 32'(last_din), 32'(8'h9E));
    check("post_rst_gid", 32'(last_gid), 32'(1));
    req_valid = 2'b11;
    wait_main(2, 200);
    check("post_rst_next_gid", 32'(q_gid[1]), 32'(0));
    check("post_rst_next_din", 32'(q_din[1]), 32'(8'h55));
    req_valid = '0;
    wait_idle(200);

    // Valid pulsed while busy is dropped.
    do_reset();
    req_data[7:0] = 8'h11;
    req_valid     = 2'b01;
    cyc(1'b0);
    req_valid = '0;
    for (int i = 0; i < 6; i++) pat_cyc();
    req_valid = 2'b01;
    pat_cyc();
    check("drop_ready", 32'(last_ready), 32'(2'b00));
    req_valid = '0;
    wait_idle(200);
    for (int i = 0; i < 40; i++) pat_cyc();
    check("drop_strobes", 32'(q_din.size()), 32'(1));
    check("drop_idle", 32'(last_busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
